ball_kinematics: RTL
====================

// Module: ball_kinematics
// PURPOSE
// Per-ball motion state: holds velocity and sub-pixel position, and advances position once per frame.
// Applies rolling friction and accepts cue strikes.
// Sits directly downstream of the border collision stage: consumes its reflected velocities on the
// collision pulse. Feeds position and velocity back to that stage and to the ball drawer.
// PARAMETERS
// INIT_X          100   reset top-left X, whole pixels
// INIT_Y          100   reset top-left Y, whole pixels
// MIN_X           0     lowest legal top-left X, pixels (position clamp)
// MAX_X           607   highest legal top-left X, pixels
// MIN_Y           0     lowest legal top-left Y, pixels
// MAX_Y           447   highest legal top-left Y, pixels
// FRAC_BITS       4     fractional bits of position and velocity (units of 1/16 pixel)
// FRICTION_SHIFT  6     per-frame decay: v -= v>>>FRICTION_SHIFT
// PORTS
// clk               in   1   system clock
// resetN            in   1   asynchronous, active-low reset
// startOfFrame      in   1   1-cycle pulse, once per video frame
// collisionOccurred in   1   1-cycle pulse from the border collision stage
// ballVelXIn        in   11  signed reflected X velocity, valid with collisionOccurred
// ballVelYIn        in   11  signed reflected Y velocity, valid with collisionOccurred
// strikeValid       in   1   cue strike request, level; held until strikeAccepted
// strikeVelX        in   11  signed strike X velocity
// strikeVelY        in   11  signed strike Y velocity
// strikeAccepted    out  1   1-cycle pulse, strike loaded
// ballTopLeftPosX   out  11  signed pixel X = posX_fp>>>FRAC_BITS
// ballTopLeftPosY   out  11  signed pixel Y
// ballVelX          out  11  signed current X velocity
// ballVelY          out  11  signed current Y velocity
// ballMoving        out  1   combinational: ballVelX!=0 || ballVelY!=0
// BEHAVIOUR
// - Reset (async): posX_fp=INIT_X<<FRAC_BITS, posY_fp=INIT_Y<<FRAC_BITS, velocities 0, state IDLE,
//   strikeAccepted 0. ballMoving is therefore 0.
// - Positions are 15-bit signed internally (11 integer bits + FRAC_BITS). Sums use 16 bits, then clamp.
// - FSM: IDLE -> MOVE on startOfFrame; MOVE -> DECAY (1 cycle); DECAY -> IDLE (1 cycle).
//   startOfFrame outside IDLE is ignored.
// - MOVE: pos_fp += sign-extended vel per axis; result clamped to [MIN<<FRAC_BITS, MAX<<FRAC_BITS].
//   Clamping does not change velocity; reflection is the collision stage's job.
// - DECAY, per axis, on v: if v==0, hold.
//   If |v| >= 2^FRICTION_SHIFT: v <= v - (v>>>FRICTION_SHIFT).
//   Else v <= v - sign(v), i.e. step 1 toward 0.
//   Velocity never crosses zero; -1024 must be handled without overflow.
// - Velocity write priority, same cycle: collisionOccurred > DECAY > strike.
//   collisionOccurred in any state: vel <= ballVelIn (both axes) next edge.
//   If that cycle is DECAY, the decay for that frame is dropped.
// - Strike: accepted only in IDLE with ballMoving==0, and no collisionOccurred that cycle.
//   Effect: vel <= strikeVel, strikeAccepted=1 for one cycle. Otherwise the request waits;
//   a strike is never dropped while strikeValid stays high.
// - Position latency: outputs reflect MOVE at the edge ending MOVE.
//   Pixel outputs change at most once per frame.
// - resetN low mid-FSM: returns to IDLE, all registers back to reset values, any pending strike unacknowledged.
// TESTING
// - Reset, then idle 3 frames -> pos (100,100), vel (0,0), ballMoving=0, strikeAccepted never high.
// - strikeValid vel (32,-16) in IDLE -> strikeAccepted 1 cycle.
//   Next frame: pos_fp X +32 (pixel 102), Y -16 (pixel 99).
//   DECAY: vx 32->31, vy -16->-15.
// - vel (640,0) over one frame -> vx 640->630. vel (1,0) -> 0 after one frame, stays 0, ballMoving drops.
// - collisionOccurred with (-20,7) coincident with DECAY -> vel exactly (-20,7); no decay that frame.
// - INIT_X=600, vx=+400 -> X clamps at 607 and stays; vx unchanged by clamp.
// - strikeValid held while moving -> accepted on first IDLE cycle after vel reaches (0,0); resetN low mid-MOVE -> INIT pos, vel 0.

Source files
------------

// File: rtl/ball_kinematics.sv
// Per-ball motion state: sub-pixel position and velocity, advanced once per frame
// with rolling friction, border-collision velocity loads and cue strikes.
module ball_kinematics #(
  parameter int INIT_X         = 100,
  parameter int INIT_Y         = 100,
  parameter int MIN_X          = 0,
  parameter int MAX_X          = 607,
  parameter int MIN_Y          = 0,
  parameter int MAX_Y          = 447,
  parameter int FRAC_BITS      = 4,
  parameter int FRICTION_SHIFT = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collisionOccurred,
  input  logic signed [10:0] ballVelXIn,
  input  logic signed [10:0] ballVelYIn,
  input  logic               strikeValid,
  input  logic signed [10:0] strikeVelX,
  input  logic signed [10:0] strikeVelY,
  output logic               strikeAccepted,
  output logic signed [10:0] ballTopLeftPosX,
  output logic signed [10:0] ballTopLeftPosY,
  output logic signed [10:0] ballVelX,
  output logic signed [10:0] ballVelY,
  output logic               ballMoving
);

  // state | meaning
  // IDLE  | waiting for startOfFrame; only state where a strike can load
  // MOVE  | position += velocity, clamped to the legal box
  // DECAY | friction applied to velocity
  typedef enum logic [1:0] {IDLE, MOVE, DECAY} state_t;

  localparam int PW = 11 + FRAC_BITS;

  localparam logic signed [PW:0] MIN_X_FP = (PW+1)'(MIN_X << FRAC_BITS);
  localparam logic signed [PW:0] MAX_X_FP = (PW+1)'(MAX_X << FRAC_BITS);
  localparam logic signed [PW:0] MIN_Y_FP = (PW+1)'(MIN_Y << FRAC_BITS);
  localparam logic signed [PW:0] MAX_Y_FP = (PW+1)'(MAX_Y << FRAC_BITS);
  localparam logic signed [PW-1:0] INIT_X_FP = PW'(INIT_X << FRAC_BITS);
  localparam logic signed [PW-1:0] INIT_Y_FP = PW'(INIT_Y << FRAC_BITS);
  localparam logic signed [10:0] DECAY_THR = 11'(1 << FRICTION_SHIFT);

  state_t state_q, state_d;
  logic signed [PW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [10:0]   vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic                 strike_acc_q, strike_acc_d;
  logic                 strike_take;

  // Sum is one bit wider than the position so it can be compared before clamping.
  function automatic logic signed [PW-1:0] step_pos(
    input logic signed [PW-1:0] pos,
    input logic signed [10:0]   vel,
    input logic signed [PW:0]   lo,
    input logic signed [PW:0]   hi
  );
    logic signed [PW:0] sum;
    logic signed [PW-1:0] r;
    sum = {pos[PW-1], pos} + {{(PW+1-11){vel[10]}}, vel};
    if (sum < lo)      r = lo[PW-1:0];
    else if (sum > hi) r = hi[PW-1:0];
    else               r = sum[PW-1:0];
    return r;
  endfunction

  // Small magnitudes step by one so the ball always comes to rest; never crosses zero.
  function automatic logic signed [10:0] decay(input logic signed [10:0] v);
    logic signed [10:0] r;
    if (v == 11'sd0)                           r = v;
    else if ((v >= DECAY_THR) || (v <= -DECAY_THR)) r = v - (v >>> FRICTION_SHIFT);
    else if (v[10])                            r = v + 11'sd1;
    else                                       r = v - 11'sd1;
    return r;
  endfunction

  assign ballMoving  = (vel_x_q != 11'sd0) || (vel_y_q != 11'sd0);
  assign strike_take = (state_q == IDLE) && strikeValid && !ballMoving &&
                       !collisionOccurred && !strike_acc_q;

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    strike_acc_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (startOfFrame) state_d = MOVE;
      end
      MOVE: begin
        pos_x_d = step_pos(pos_x_q, vel_x_q, MIN_X_FP, MAX_X_FP);
        pos_y_d = step_pos(pos_y_q, vel_y_q, MIN_Y_FP, MAX_Y_FP);
        state_d = DECAY;
      end
      DECAY: begin
        vel_x_d = decay(vel_x_q);
        vel_y_d = decay(vel_y_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Collision overrides the frame's decay; strikes only ever land in IDLE.
    if (collisionOccurred) begin
      vel_x_d = ballVelXIn;
      vel_y_d = ballVelYIn;
    end else if (strike_take) begin
      vel_x_d      = strikeVelX;
      vel_y_d      = strikeVelY;
      strike_acc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      pos_x_q      <= INIT_X_FP;
      pos_y_q      <= INIT_Y_FP;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      strike_acc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      strike_acc_q <= strike_acc_d;
    end
  end

  assign strikeAccepted  = strike_acc_q;
  assign ballTopLeftPosX = pos_x_q[PW-1:FRAC_BITS];
  assign ballTopLeftPosY = pos_y_q[PW-1:FRAC_BITS];
  assign ballVelX        = vel_x_q;
  assign ballVelY        = vel_y_q;

endmodule
